// File: rtl/imem_pc.sv
// imem_pc: free-running RV32 fetch stage, a PC register driving a fixed instruction ROM
module imem_pc #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] inst
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PROG [8] = '{
    32'h0050_0093, 32'h0030_0113, 32'h0020_81B3, 32'h4020_8233,
    32'h0020_F2B3, 32'h0020_E333, 32'h0020_C3B3, NOP
  };
  // power-up value makes inst defined before the first reset edge
  logic [31:0]   pc = RESET_PC;
  logic [AW-1:0] idx;
  always_ff @(posedge CLK) pc <= RST ? RESET_PC : pc + 32'd4;
  assign idx = pc[AW+1:2];
  always_comb inst = (idx >> 3) == '0 ? PROG[idx[2:0]] : NOP;
endmodule

// File: tb/tb_imem_pc.sv
// tb_imem_pc: scoreboard bench for the free-running fetch stage
module tb_imem_pc;
  localparam int MEM_DEPTH = 64;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] inst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] exp_q [$];

  imem_pc #(.MEM_DEPTH(MEM_DEPTH), .RESET_PC(32'h0)) dut (.CLK(CLK), .RST(RST), .inst(inst));

  initial begin
    #45;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] rom_m(input logic [31:0] pc);
    int i;
    i = int'(pc[31:2]) % MEM_DEPTH;
    case (i)
      0: return 32'h00500093;
      1: return 32'h00300113;
      2: return 32'h002081B3;
      3: return 32'h40208233;
      4: return 32'h0020F2B3;
      5: return 32'h0020E333;
      6: return 32'h0020C3B3;
      default: return 32'h00000013;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic r);
    return rom_m(r ? 32'h0 : m_pc + 32'd4);
  endfunction

  task automatic step(input logic r, input logic [31:0] exp, input string nm);
    logic [31:0] e;
    RST = r;
    exp_q.push_back(exp);
    @(posedge CLK);
    m_pc = r ? 32'h0 : m_pc + 32'd4;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (inst !== e) begin
      errors++;
      $display("FAIL %s: inst=%h expected=%h at %0t", nm, inst, e, $time);
    end
    RST = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (inst !== 32'h00500093) begin
      errors++;
      $display("FAIL powerup: inst=%h expected=00500093", inst);
    end
    #9 RST = 1'b1;
    #10 RST = 1'b0;
    #10;
    checks++;
    if (inst !== 32'h00500093) begin
      errors++;
      $display("FAIL pulse_no_edge_30: inst=%h expected=00500093", inst);
    end
    #15;
    checks++;
    if (inst !== 32'h00500093) begin
      errors++;
      $display("FAIL pulse_no_edge_45: inst=%h expected=00500093", inst);
    end
  endtask

  task automatic test_freerun;
    logic [31:0] seq [6] = '{32'h00300113, 32'h002081B3, 32'h40208233,
                             32'h0020F2B3, 32'h0020E333, 32'h0020C3B3};
    for (int i = 0; i < 6; i++) step(1'b0, seq[i], $sformatf("freerun_%0d", i + 1));
  endtask

  task automatic test_tail;
    for (int i = 7; i <= 10; i++) step(1'b0, 32'h00000013, $sformatf("tail_%0d", i));
  endtask

  task automatic test_reset_mid;
    step(1'b1, 32'h00500093, "realign_reset");
    for (int i = 1; i <= 5; i++) step(1'b0, model_next(1'b0), $sformatf("advance_%0d", i));
    step(1'b1, 32'h00500093, "mid_reset");
    step(1'b0, 32'h00300113, "after_mid_reset");
  endtask

  task automatic test_reset_held;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00500093, $sformatf("held_%0d", i));
      RST = 1'b1;
      @(negedge CLK);
      checks++;
      if (inst !== 32'h00500093) begin
        errors++;
        $display("FAIL held_mid_%0d: inst=%h expected=00500093", i, inst);
      end
    end
  endtask

  task automatic test_wrap;
    for (int i = 1; i < MEM_DEPTH; i++) step(1'b0, model_next(1'b0), $sformatf("wrap_run_%0d", i));
    step(1'b0, 32'h00500093, "wrap_64");
    step(1'b0, 32'h00300113, "wrap_65");
    step(1'b0, 32'h002081B3, "wrap_66");
    for (int i = 67; i < 72; i++) step(1'b0, model_next(1'b0), $sformatf("wrap_%0d", i));
  endtask

  initial begin
    test_reset;
    test_freerun;
    test_tail;
    test_reset_mid;
    test_reset_held;
    RST = 1'b0;
    test_wrap;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_pc.md
Name: imem_pc

Overview:
- Instruction-fetch stage of an RV32 core: a 32-bit program counter (PC) register drives a read-only instruction memory.
- The PC advances one word (PC+4) every clock. The addressed instruction word is presented combinationally on `inst`.
- No branch or jump input exists. This is a free-running sequential fetch unit used to bring up the fetch path.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in the instruction ROM; must be a power of two, at least 8.
- RESET_PC, 32'h00000000, PC value loaded by reset and at power-up.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- inst  output  32  instruction word at the current PC, combinational from PC.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is synchronous and active-high.
- PC register, 32 bits:
  - At each rising CLK edge with RST=1, PC <= RESET_PC.
  - Otherwise PC <= PC + 4, modulo 2^32, so it wraps from 0xFFFFFFFC to 0x00000000.
- Power-up value: PC is initialised to RESET_PC at time zero, so `inst` is defined before any reset edge. A RST pulse that sees no rising edge has no effect.
- Memory addressing:
  - Word index = PC[log2(MEM_DEPTH)+1 : 2].
  - PC[1:0] is ignored.
  - Higher PC bits alias, so the fetch sequence wraps through the ROM every MEM_DEPTH cycles.
- Read path: `inst` = ROM[index], combinational with zero latency. `inst` changes only after the PC changes, i.e. just after a rising edge.
- ROM contents are fixed at elaboration and there is no write port. The contents (word index : value) are:
  - 0 : 32'h00500093 (addi x1,x0,5)
  - 1 : 32'h00300113 (addi x2,x0,3)
  - 2 : 32'h002081B3 (add x3,x1,x2)
  - 3 : 32'h40208233 (sub x4,x1,x2)
  - 4 : 32'h0020F2B3 (and x5,x1,x2)
  - 5 : 32'h0020E333 (or x6,x1,x2)
  - 6 : 32'h0020C3B3 (xor x7,x1,x2)
  - 7 .. MEM_DEPTH-1 : 32'h00000013 (nop)
- Reset mid-run: at the next rising edge with RST=1, PC returns to RESET_PC. `inst` then equals ROM[RESET_PC index]. Fetching resumes at RESET_PC+4 on the first edge after RST is low.
- RST held high for several edges: PC stays at RESET_PC and `inst` stays constant.
- No X or Z on `inst` at any time after time zero.

Test Plan:
- Power-up, no edge yet: at time 0, `inst`=32'h00500093. A RST pulse between edges (high 10–20 ns, edge at 50 ns) leaves `inst` unchanged until the first edge.
- Free-run sequence: after each of the first 6 rising edges, `inst` = 32'h00300113, 002081B3, 40208233, 0020F2B3, 0020E333, 0020C3B3, in that order.
- Tail fill: after edges 7–10, `inst`=32'h00000013.
- Synchronous reset mid-run: assert RST for one edge while at index 5. After that edge `inst`=32'h00500093. After the next edge (RST=0) `inst`=32'h00300113.
- Reset held: RST high for 3 edges, then `inst`=32'h00500093 throughout.
- Wrap-around: after exactly MEM_DEPTH (64) edges from RESET_PC with no reset, `inst`=32'h00500093 again, and the sequence repeats.
